// File: rtl/multicycle_proc_p.sv
// Four-state multicycle processor (IDLE/EXEC/MEM/WB) with register file, data memory and PRINT port.
// Optional MUL on opcode 12 when MULTICYCLE_PROC_P_MUL_EN is defined.
module multicycle_proc_p #(
   parameter int DATA_W  = 16,
   parameter int FIELD_W = 4,
   parameter int MEM_AW  = 4
) (
   input  logic                   clock_i,
   input  logic                   reset_ni,
   input  logic                   run_i,
   input  logic [4+3*FIELD_W-1:0] input_i,
   output logic                   done_o,
   output logic                   busy_o,
   output logic                   illegal_o,
   output logic [DATA_W-1:0]      output_o
);
   localparam int IW   = 4 + 3*FIELD_W;
   localparam int NREG = 1 << FIELD_W;
   localparam int NMEM = 1 << MEM_AW;
   localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_MVNZ  = 4'd3;
   localparam logic [3:0] OP_MV    = 4'd4;
   localparam logic [3:0] OP_MVI   = 4'd5;
   localparam logic [3:0] OP_ADD   = 4'd6;
   localparam logic [3:0] OP_SUB   = 4'd7;
   localparam logic [3:0] OP_AND   = 4'd8;
   localparam logic [3:0] OP_SLT   = 4'd9;
   localparam logic [3:0] OP_SLL   = 4'd10;
   localparam logic [3:0] OP_SRL   = 4'd11;
   localparam logic [3:0] OP_MUL   = 4'd12;
   localparam logic [3:0] OP_PRINT = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       ir_q, ir_d;
   logic [DATA_W-1:0]   temp_q, temp_d;
   logic                done_q, done_d;
   logic                illegal_q, illegal_d;
   logic [DATA_W-1:0]   out_q, out_d;
   logic [DATA_W-1:0]   regs_q [NREG];
   logic [DATA_W-1:0]   mem_q  [NMEM];
   logic                reg_we, mem_we;

   logic [3:0]          opcode;
   logic [FIELD_W-1:0]  fa, fb, fc;
   logic [DATA_W-1:0]   ra, rb, rc;
   logic [MEM_AW-1:0]   maddr;
   logic [DATA_W-1:0]   exec_res;
   logic                op_legal;

   assign opcode = ir_q[IW-1 -: 4];
   assign fa     = ir_q[3*FIELD_W-1 -: FIELD_W];
   assign fb     = ir_q[2*FIELD_W-1 -: FIELD_W];
   assign fc     = ir_q[FIELD_W-1:0];
   assign ra     = regs_q[fa];
   assign rb     = regs_q[fb];
   assign rc     = regs_q[fc];
   // temp holds the effective address between EXEC and MEM
   assign maddr  = temp_q[MEM_AW-1:0];

   always_comb begin
      exec_res = '0;
      op_legal = 1'b1;
      case (opcode)
         OP_NOP, OP_PRINT:  exec_res = '0;
         OP_STORE, OP_LOAD: exec_res = rb + DATA_W'(fc);
         OP_MVNZ:           exec_res = (rc == '0) ? ra : rb;
         OP_MV:             exec_res = rb;
         OP_MVI:            exec_res = DATA_W'({fb, fc});
         OP_ADD:            exec_res = rb + rc;
         OP_SUB:            exec_res = rb - rc;
         OP_AND:            exec_res = rb & rc;
         OP_SLT:            exec_res = {{(DATA_W-1){1'b0}}, (rb < rc)};
         OP_SLL:            exec_res = (rc >= SHIFT_LIM) ? '0 : (rb << rc);
         OP_SRL:            exec_res = (rc >= SHIFT_LIM) ? '0 : (rb >> rc);
`ifdef MULTICYCLE_PROC_P_MUL_EN
         OP_MUL:            exec_res = rb * rc;
`else
         OP_MUL:            op_legal = 1'b0;
`endif
         default:           op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      temp_d    = temp_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      out_d     = out_q;
      reg_we    = 1'b0;
      mem_we    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (run_i) begin
               ir_d    = input_i;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            temp_d  = exec_res;
            state_d = S_WB;
            if (opcode == OP_STORE || opcode == OP_LOAD) begin
               state_d = S_MEM;
            end else if (opcode == OP_NOP || opcode == OP_PRINT || !op_legal) begin
               state_d   = S_IDLE;
               done_d    = 1'b1;
               illegal_d = !op_legal;
               if (opcode == OP_PRINT) out_d = ra;
            end
         end
         S_MEM: begin
            if (opcode == OP_STORE) begin
               mem_we  = 1'b1;
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               temp_d  = mem_q[maddr];
               state_d = S_WB;
            end
         end
         S_WB: begin
            reg_we  = 1'b1;
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= S_IDLE;
         ir_q      <= '0;
         temp_q    <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         out_q     <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= DATA_W'(i);
         for (int i = 0; i < NMEM; i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         temp_q    <= temp_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         out_q     <= out_d;
         if (reg_we) regs_q[fa] <= temp_q;
         if (mem_we) mem_q[maddr] <= ra;
      end
   end

   assign done_o    = done_q;
   assign busy_o    = (state_q != S_IDLE);
   assign illegal_o = illegal_q;
   assign output_o  = out_q;
endmodule

// File: tb/tb_multicycle_proc_p.sv
// Self-checking bench for multicycle_proc_p: directed vector table, reset/abort and
// run-while-busy sequences, then random instructions against an arithmetic reference model.
module tb_multicycle_proc_p;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [15:0] instr_in = '0;
   logic        done_o, busy_o, illegal_o;
   logic [15:0] output_o;

   int checks = 0;
   int errors = 0;

   int m_r [16];
   int m_mem [16];
   int m_out;

   typedef struct {
      logic [15:0] ins;
      int          lat;
      logic        ill;
      logic [15:0] out;
   } vec_t;

   vec_t vecs [31];

   multicycle_proc_p dut (
      .clock_i  (clk),
      .reset_ni (rst_n),
      .run_i    (run),
      .input_i  (instr_in),
      .done_o   (done_o),
      .busy_o   (busy_o),
      .illegal_o(illegal_o),
      .output_o (output_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Issue one instruction from the current (IDLE) cycle and follow it to its Done pulse.
   task automatic run_instr(input logic [15:0] ins, input int exp_lat, input logic exp_ill,
                            input logic [15:0] exp_out, input bit junk);
      int lat;
      int busy_cnt;
      lat = 0;
      busy_cnt = 0;
      run = 1'b1;
      instr_in = ins;
      @(posedge clk); #1;
      run = 1'b0;
      chk("done_low_after_capture", done_o, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         if (busy_o) busy_cnt++;
         if (junk && k < exp_lat) begin
            run = 1'($urandom_range(0, 1));
            instr_in = 16'($urandom);
         end else begin
            run = 1'b0;
         end
         @(posedge clk); #1;
         if (done_o) begin
            lat = k;
            break;
         end
      end
      run = 1'b0;
      chk("latency", lat, exp_lat);
      chk("busy_cycles", busy_cnt, exp_lat);
      chk("busy_low_at_done", busy_o, 1'b0);
      chk("illegal", illegal_o, exp_ill);
      chk("output", output_o, exp_out);
      $display("instr %h latency %0d illegal %0b output %h", ins, lat, illegal_o, output_o);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_r[i] = i;
         m_mem[i] = 0;
      end
      m_out = 0;
   endtask

   task automatic model_step(input logic [15:0] ins, output int lat, output logic ill);
      int op, a, b, c, addr;
      op = int'(ins[15:12]);
      a  = int'(ins[11:8]);
      b  = int'(ins[7:4]);
      c  = int'(ins[3:0]);
      addr = (m_r[b] + c) % 16;
      ill = 1'b0;
      lat = 2;
      case (op)
         0:  lat = 1;
         1:  m_mem[addr] = m_r[a];
         2:  begin m_r[a] = m_mem[addr]; lat = 3; end
         3:  m_r[a] = (m_r[c] == 0) ? m_r[a] : m_r[b];
         4:  m_r[a] = m_r[b];
         5:  m_r[a] = b * 16 + c;
         6:  m_r[a] = (m_r[b] + m_r[c]) % 65536;
         7:  m_r[a] = (m_r[b] - m_r[c] + 65536) % 65536;
         8:  m_r[a] = m_r[b] & m_r[c];
         9:  m_r[a] = (m_r[b] < m_r[c]) ? 1 : 0;
         10: m_r[a] = (m_r[c] >= 16) ? 0 : (m_r[b] * (1 << m_r[c])) % 65536;
         11: m_r[a] = (m_r[c] >= 16) ? 0 : m_r[b] / (1 << m_r[c]);
`ifdef MULTICYCLE_PROC_P_MUL_EN
         12: m_r[a] = int'((longint'(m_r[b]) * longint'(m_r[c])) % 65536);
`else
         12: begin lat = 1; ill = 1'b1; end
`endif
         15: begin m_out = m_r[a]; lat = 1; end
         default: begin lat = 1; ill = 1'b1; end
      endcase
   endtask

   task automatic do_step(input logic [15:0] ins, input bit junk);
      int lat;
      logic ill;
      model_step(ins, lat, ill);
      run_instr(ins, lat, ill, 16'(m_out), junk);
   endtask

   initial begin
      logic [15:0] mul_out;
      int          mul_lat;
      logic        mul_ill;
      bit          seen_done;
`ifdef MULTICYCLE_PROC_P_MUL_EN
      mul_out = 16'h002A; mul_lat = 2; mul_ill = 1'b0;
`else
      mul_out = 16'h0005; mul_lat = 1; mul_ill = 1'b1;
`endif
      vecs[0]  = '{16'hF300, 1, 1'b0, 16'h0003};
      vecs[1]  = '{16'h7101, 2, 1'b0, 16'h0003};
      vecs[2]  = '{16'hF100, 1, 1'b0, 16'hFFFF};
      vecs[3]  = '{16'h6123, 2, 1'b0, 16'hFFFF};
      vecs[4]  = '{16'hF100, 1, 1'b0, 16'h0005};
      vecs[5]  = '{16'h1402, 2, 1'b0, 16'h0005};
      vecs[6]  = '{16'h2502, 3, 1'b0, 16'h0005};
      vecs[7]  = '{16'hF500, 1, 1'b0, 16'h0004};
      vecs[8]  = '{16'hD100, 1, 1'b1, 16'h0004};
      vecs[9]  = '{16'hF100, 1, 1'b0, 16'h0005};
      vecs[10] = '{16'hC167, mul_lat, mul_ill, 16'h0005};
      vecs[11] = '{16'hF100, 1, 1'b0, mul_out};
      vecs[12] = '{16'hE000, 1, 1'b1, mul_out};
      vecs[13] = '{16'h0000, 1, 1'b0, mul_out};
      vecs[14] = '{16'h5A12, 2, 1'b0, mul_out};
      vecs[15] = '{16'hFA00, 1, 1'b0, 16'h0012};
      vecs[16] = '{16'h9234, 2, 1'b0, 16'h0012};
      vecs[17] = '{16'hF200, 1, 1'b0, 16'h0001};
      vecs[18] = '{16'hA673, 2, 1'b0, 16'h0001};
      vecs[19] = '{16'hF600, 1, 1'b0, 16'h0038};
      vecs[20] = '{16'h5910, 2, 1'b0, 16'h0038};
      vecs[21] = '{16'hB8F9, 2, 1'b0, 16'h0038};
      vecs[22] = '{16'hF800, 1, 1'b0, 16'h0000};
      vecs[23] = '{16'h3378, 2, 1'b0, 16'h0000};
      vecs[24] = '{16'hF300, 1, 1'b0, 16'h0003};
      vecs[25] = '{16'h3372, 2, 1'b0, 16'h0003};
      vecs[26] = '{16'hF300, 1, 1'b0, 16'h0007};
      vecs[27] = '{16'h8CDE, 2, 1'b0, 16'h0007};
      vecs[28] = '{16'hFC00, 1, 1'b0, 16'h000C};
      vecs[29] = '{16'h2BF3, 3, 1'b0, 16'h000C};
      vecs[30] = '{16'hFB00, 1, 1'b0, 16'h0004};

      // Reset state, with Run already high so the first edge after release captures.
      run = 1'b1;
      instr_in = 16'hF300;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_done", done_o, 1'b0);
      chk("reset_busy", busy_o, 1'b0);
      chk("reset_illegal", illegal_o, 1'b0);
      chk("reset_output", output_o, 16'h0000);
      rst_n = 1'b1;

      // Back-to-back table: each instruction is captured in the previous Done cycle.
      for (int i = 0; i < 31; i++)
         run_instr(vecs[i].ins, vecs[i].lat, vecs[i].ill, vecs[i].out, 1'b0);

      // Abort a LOAD in its MEM state.
      run = 1'b1;
      instr_in = 16'h2502;
      @(posedge clk); #1;
      run = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy_in_mem", busy_o, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy_o, 1'b0);
      chk("abort_done", done_o, 1'b0);
      chk("abort_output", output_o, 16'h0000);
      seen_done = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (done_o) seen_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (done_o) seen_done = 1'b1;
      end
      chk("abort_no_done", seen_done, 1'b0);
      chk("abort_idle", busy_o, 1'b0);
      model_reset();
      do_step(16'hF500, 1'b0);
      chk("abort_r5", output_o, 16'h0005);
      do_step(16'h2602, 1'b0);
      do_step(16'hF600, 1'b0);
      chk("abort_mem_cleared", output_o, 16'h0000);

      // Run held through EXEC with a PRINT on the bus: must not be queued.
      run = 1'b1;
      instr_in = 16'h6123;
      @(posedge clk); #1;
      instr_in = 16'hF300;
      @(posedge clk); #1;
      run = 1'b0;
      chk("busy_wb", busy_o, 1'b1);
      @(posedge clk); #1;
      chk("add_done", done_o, 1'b1);
      @(posedge clk); #1;
      chk("run_not_queued", busy_o, 1'b0);
      chk("done_one_cycle", done_o, 1'b0);
      chk("print_ignored", output_o, 16'h0000);
      begin
         int lt;
         logic il;
         model_step(16'h6123, lt, il);
      end
      do_step(16'hF100, 1'b0);

      // Random instructions, PRINT-biased, with Run noise during busy cycles.
      for (int n = 0; n < 250; n++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) op = 4'hF;
         do_step({op, 12'($urandom)}, 1'($urandom_range(0, 1)));
      end
      for (int r = 0; r < 16; r++)
         do_step({4'hF, 4'(r), 8'h00}, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
